unified_mem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between two requesters: instruction fetch (IF) and the memory-stage data port (DM).
- Sequences every access with a small FSM and a latency counter.
- Returns per-requester ready pulses; the pipeline uses ~ready as its stall source.
- Sits between the fetch / memory-stage logic and the shared RAM.

---
 rtl/unified_mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: arbitrates one fixed-latency single-port RAM between
// instruction fetch (IF) and the data port (DM). Each access passes through
// IDLE -> ISSUE -> WAIT -> DONE. Every output comes from a register, so the
// outputs for a state appear in the cycle after the state-register cycle.
module unified_mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    input  logic                    if_abort_i,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    output logic                    if_ready_o,
    input  logic                    dm_req_i,
    input  logic                    dm_we_i,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dm_be_i,
    output logic [DATA_WIDTH-1:0]   dm_rdata_o,
    output logic                    dm_ready_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic                    abort_q, abort_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;

    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic                    if_ready_q, if_ready_d;
    logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;
    logic                    dm_ready_q, dm_ready_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_WIDTH-1:0]     mem_be_q, mem_be_d;

    // A requester whose ready pulse is visible this cycle still shows its old
    // request level, so it must not be granted again on this edge.
    logic if_elig, dm_elig, pick_dm, if_abort_hit;
    assign if_elig      = if_req_i & ~if_ready_q;
    assign dm_elig      = dm_req_i & ~dm_ready_q;
    assign pick_dm      = dm_elig & (~if_elig | (last_grant_q == GRANT_IF));
    assign if_abort_hit = (grant_q == GRANT_IF) & if_abort_i;

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        abort_d      = abort_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        hold_d       = hold_q;
        if_rdata_d   = if_rdata_q;
        if_ready_d   = 1'b0;
        dm_rdata_d   = dm_rdata_q;
        dm_ready_d   = 1'b0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;

        case (state_q)
            ST_IDLE: begin
                if (if_elig || dm_elig) begin
                    abort_d = 1'b0;
                    state_d = ST_ISSUE;
                    if (pick_dm) begin
                        grant_d     = GRANT_DM;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        mem_be_d    = dm_be_i;
                        we_d        = dm_we_i;
                    end else begin
                        grant_d     = GRANT_IF;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                        we_d        = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                mem_req_d = 1'b1;
                mem_we_d  = we_q;
                cnt_d     = CNT_LOAD;
                abort_d   = abort_q | if_abort_hit;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                abort_d = abort_q | if_abort_hit;
                if (cnt_q == 4'd0) begin
                    hold_d  = mem_rdata_i;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                // A flush arriving in the final cycle still cancels the fetch.
                if (grant_q == GRANT_IF) begin
                    if (!(abort_q | if_abort_i)) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = hold_q;
                    end
                end else begin
                    dm_ready_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = hold_q;
                    end
                end
                last_grant_d = grant_q;
                abort_d      = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_IF;
            last_grant_q <= GRANT_IF;
            abort_q      <= 1'b0;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            hold_q       <= '0;
            if_rdata_q   <= '0;
            if_ready_q   <= 1'b0;
            dm_rdata_q   <= '0;
            dm_ready_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            abort_q      <= abort_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            hold_q       <= hold_d;
            if_rdata_q   <= if_rdata_d;
            if_ready_q   <= if_ready_d;
            dm_rdata_q   <= dm_rdata_d;
            dm_ready_q   <= dm_ready_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ready_o  = dm_ready_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: instance 0 uses MEM_LATENCY=2, instance 1
// uses MEM_LATENCY=1. A behavioural RAM answers mem_req_o, and scoreboard
// queues hold the expected memory accesses and completions.
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic        if_req   [2];
    logic [31:0] if_addr  [2];
    logic        if_abort [2];
    logic [31:0] if_rdata [2];
    logic        if_ready [2];
    logic        dm_req   [2];
    logic        dm_we    [2];
    logic [31:0] dm_addr  [2];
    logic [31:0] dm_wdata [2];
    logic [3:0]  dm_be    [2];
    logic [31:0] dm_rdata [2];
    logic        dm_ready [2];
    logic        mem_req  [2];
    logic        mem_we   [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic [3:0]  mem_be   [2];
    logic [31:0] mem_rdata[2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        unified_mem_arbiter #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (32),
            .MEM_LATENCY(gi == 0 ? 2 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[gi]),
            .if_req_i   (if_req[gi]),
            .if_addr_i  (if_addr[gi]),
            .if_abort_i (if_abort[gi]),
            .if_rdata_o (if_rdata[gi]),
            .if_ready_o (if_ready[gi]),
            .dm_req_i   (dm_req[gi]),
            .dm_we_i    (dm_we[gi]),
            .dm_addr_i  (dm_addr[gi]),
            .dm_wdata_i (dm_wdata[gi]),
            .dm_be_i    (dm_be[gi]),
            .dm_rdata_o (dm_rdata[gi]),
            .dm_ready_o (dm_ready[gi]),
            .mem_req_o  (mem_req[gi]),
            .mem_we_o   (mem_we[gi]),
            .mem_addr_o (mem_addr[gi]),
            .mem_wdata_o(mem_wdata[gi]),
            .mem_be_o   (mem_be[gi]),
            .mem_rdata_i(mem_rdata[gi])
        );
    end

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          due;
    } rsp_t;

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mop_t;

    rsp_t        if_q[$];
    rsp_t        dm_q[$];
    mop_t        mem_q[$];
    logic [31:0] ram [logic [31:0]];

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          pend      [2];
    int          issue_cyc [2];
    logic [31:0] pdata     [2];
    logic        prev_req  [2];

    function automatic int lat(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model plus memory-side and completion-side scoreboards.
    always @(negedge clk) begin
        mop_t        m;
        rsp_t        r;
        logic [31:0] w;
        for (int i = 0; i < 2; i++) begin
            if (mem_req[i] === 1'b1) begin
                chk("mem_req_back2back", 32'(prev_req[i]), 32'h0);
                if (mem_q.size() == 0) begin
                    chk("mem_req_unexpected", 32'(mem_req[i]), 32'h0);
                end else begin
                    m = mem_q.pop_front();
                    chk("mem_inst", 32'(i), 32'(m.inst));
                    chk("mem_addr", mem_addr[i], m.addr);
                    chk("mem_we", 32'(mem_we[i]), 32'(m.we));
                    chk("mem_be", 32'(mem_be[i]), 32'(m.be));
                    if (m.we) chk("mem_wdata", mem_wdata[i], m.wdata);
                end
                w = ram.exists(mem_addr[i]) ? ram[mem_addr[i]] : 32'h0;
                if (mem_we[i] === 1'b1) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[i][b]) w[8*b +: 8] = mem_wdata[i][8*b +: 8];
                    ram[mem_addr[i]] = w;
                end else begin
                    pend[i]      = 1'b1;
                    issue_cyc[i] = cyc;
                    pdata[i]     = w;
                end
            end
            prev_req[i] = mem_req[i];

            if (pend[i] && cyc == issue_cyc[i] + lat(i) - 1) begin
                mem_rdata[i] = pdata[i];
                pend[i]      = 1'b0;
            end else begin
                mem_rdata[i] = 32'hBAD0_BAD0;
            end

            if (if_ready[i] === 1'b1) begin
                if (if_q.size() == 0) begin
                    chk("if_ready_unexpected", 32'(if_ready[i]), 32'h0);
                end else begin
                    r = if_q.pop_front();
                    chk("if_inst", 32'(i), 32'(r.inst));
                    chk("if_rdata", if_rdata[i], r.data);
                    chk("if_latency", 32'(cyc), 32'(r.due));
                end
            end
            if (dm_ready[i] === 1'b1) begin
                if (dm_q.size() == 0) begin
                    chk("dm_ready_unexpected", 32'(dm_ready[i]), 32'h0);
                end else begin
                    r = dm_q.pop_front();
                    chk("dm_inst", 32'(i), 32'(r.inst));
                    chk("dm_rdata", dm_rdata[i], r.data);
                    chk("dm_latency", 32'(cyc), 32'(r.due));
                end
            end
        end
    end

    task automatic wait_ready(int i, bit is_dm);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!is_dm && if_ready[i] === 1'b1) begin
                if_req[i] = 1'b0;
                return;
            end
            if (is_dm && dm_ready[i] === 1'b1) begin
                dm_req[i] = 1'b0;
                return;
            end
        end
        chk(is_dm ? "dm_ready_timeout" : "if_ready_timeout",
            32'(is_dm ? dm_ready[i] : if_ready[i]), 32'h1);
        if_req[i] = 1'b0;
        dm_req[i] = 1'b0;
    endtask

    task automatic do_if(int i, logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        if_addr[i] = a;
        if_req[i]  = 1'b1;
        if_q.push_back('{inst: i, data: d, due: cyc + lat(i) + 3});
        mem_q.push_back('{inst: i, addr: a, we: 1'b0, wdata: 32'h0, be: 4'hF});
        wait_ready(i, 1'b0);
    endtask

    task automatic do_dm(int i, logic we, logic [31:0] a, logic [31:0] wd,
                         logic [3:0] be, logic [31:0] exp_rdata);
        @(negedge clk);
        dm_we[i]    = we;
        dm_addr[i]  = a;
        dm_wdata[i] = wd;
        dm_be[i]    = be;
        dm_req[i]   = 1'b1;
        dm_q.push_back('{inst: i, data: exp_rdata, due: cyc + lat(i) + 3});
        mem_q.push_back('{inst: i, addr: a, we: we, wdata: wd, be: be});
        wait_ready(i, 1'b1);
    endtask

    task automatic chk_outputs_zero(int i, string tag);
        chk({tag, "_if_rdata"}, if_rdata[i], 32'h0);
        chk({tag, "_if_ready"}, 32'(if_ready[i]), 32'h0);
        chk({tag, "_dm_rdata"}, dm_rdata[i], 32'h0);
        chk({tag, "_dm_ready"}, 32'(dm_ready[i]), 32'h0);
        chk({tag, "_mem_req"}, 32'(mem_req[i]), 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we[i]), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr[i], 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata[i], 32'h0);
        chk({tag, "_mem_be"}, 32'(mem_be[i]), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n_if;
        int n_dm;

        for (int i = 0; i < 2; i++) begin
            rst[i]      = 1'b1;
            if_req[i]   = 1'b0;
            if_addr[i]  = 32'h0;
            if_abort[i] = 1'b0;
            dm_req[i]   = 1'b0;
            dm_we[i]    = 1'b0;
            dm_addr[i]  = 32'h0;
            dm_wdata[i] = 32'h0;
            dm_be[i]    = 4'h0;
        end
        ram[32'h0000_0010] = 32'h0051_3093;
        ram[32'h0000_0020] = 32'h0000_0013;
        ram[32'h0000_0030] = 32'hFFFF_0000;
        ram[32'h0000_0034] = 32'h00A0_0113;
        ram[32'h0000_0044] = 32'h0FF0_000F;
        ram[32'h0000_0100] = 32'hCAFE_0001;
        ram[32'h0000_0200] = 32'hA5A5_0200;
        ram[32'h0000_0300] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        chk_outputs_zero(0, "reset0");
        chk_outputs_zero(1, "reset1");
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // IF-only read.
        do_if(0, 32'h0000_0010, 32'h0051_3093);

        // Fetch flushed during WAIT: access issued, no ready, data kept.
        @(negedge clk);
        if_addr[0] = 32'h0000_0030;
        if_req[0]  = 1'b1;
        mem_q.push_back('{inst: 0, addr: 32'h30, we: 1'b0, wdata: 32'h0, be: 4'hF});
        repeat (2) @(negedge clk);
        if_abort[0] = 1'b1;
        if_req[0]   = 1'b0;
        @(negedge clk);
        if_abort[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_rdata_kept", if_rdata[0], 32'h0051_3093);
        chk("abort_mem_issued", 32'(mem_q.size()), 32'h0);
        do_if(0, 32'h0000_0034, 32'h00A0_0113);

        // DM read, partial write (rdata unchanged), read back merged word.
        do_dm(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hCAFE_0001);
        do_dm(0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 32'hCAFE_0001);
        do_dm(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hCAFE_BEEF);

        // Both requesters held from reset: DM, IF, DM, IF every 5 cycles.
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0]     = 1'b0;
        k          = cyc;
        if_addr[0] = 32'h0000_0020;
        dm_addr[0] = 32'h0000_0200;
        dm_we[0]   = 1'b0;
        dm_be[0]   = 4'hF;
        if_req[0]  = 1'b1;
        dm_req[0]  = 1'b1;
        dm_q.push_back('{inst: 0, data: 32'hA5A5_0200, due: k + 5});
        if_q.push_back('{inst: 0, data: 32'h0000_0013, due: k + 10});
        dm_q.push_back('{inst: 0, data: 32'hA5A5_0200, due: k + 15});
        if_q.push_back('{inst: 0, data: 32'h0000_0013, due: k + 20});
        for (int j = 0; j < 2; j++) begin
            mem_q.push_back('{inst: 0, addr: 32'h200, we: 1'b0, wdata: 32'h0, be: 4'hF});
            mem_q.push_back('{inst: 0, addr: 32'h20, we: 1'b0, wdata: 32'h0, be: 4'hF});
        end
        n_if = 0;
        n_dm = 0;
        for (int t = 0; t < 40 && (n_if < 2 || n_dm < 2); t++) begin
            @(negedge clk);
            if (dm_ready[0] === 1'b1) begin
                n_dm++;
                if (n_dm == 2) dm_req[0] = 1'b0;
            end
            if (if_ready[0] === 1'b1) begin
                n_if++;
                if (n_if == 2) if_req[0] = 1'b0;
            end
        end
        if_req[0] = 1'b0;
        dm_req[0] = 1'b0;
        chk("held_if_count", 32'(n_if), 32'd2);
        chk("held_dm_count", 32'(n_dm), 32'd2);

        // Asynchronous reset in WAIT: outputs clear at once, no ready later.
        @(negedge clk);
        if_addr[0] = 32'h0000_0040;
        if_req[0]  = 1'b1;
        mem_q.push_back('{inst: 0, addr: 32'h40, we: 1'b0, wdata: 32'h0, be: 4'hF});
        repeat (2) @(negedge clk);
        #1;
        rst[0]    = 1'b1;
        if_req[0] = 1'b0;
        #1;
        chk_outputs_zero(0, "midrst");
        @(negedge clk);
        rst[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_if_rdata", if_rdata[0], 32'h0);
        do_if(0, 32'h0000_0044, 32'h0FF0_000F);

        // MEM_LATENCY=1 boundary on instance 1.
        do_dm(1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 32'h1234_5678);

        repeat (4) @(negedge clk);
        chk("if_q_empty", 32'(if_q.size()), 32'h0);
        chk("dm_q_empty", 32'(dm_q.size()), 32'h0);
        chk("mem_q_empty", 32'(mem_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
